rand_draw_sched: RTL and testbench
==================================

# rand_draw_sched

Synthesizable scheduler that shares a single random-number source among up to NUM_REQ consumers in the verification IP library. Arbitrates draws round-robin, runs a src_req/src_ack handshake with the source, and routes each sample to the winning requester. Enforces a programmable minimum spacing between draws, the clocked equivalent of a fixed sampling period. Sits between the random source and stimulus agents, so every agent sees a fair, rate-controlled stream of samples.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- DATA_W, 32: sample width.
- PERIOD_W, 16: width of period_cfg and the pace counter.
- TIMEOUT_CYC, 255: ack timeout in cycles; used only with the timeout macro.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request per consumer; held until its gnt_valid bit.
- gnt_valid  out  NUM_REQ  one-hot, single-cycle delivery strobe.
- gnt_data  out  DATA_W  sample; valid only while gnt_valid is nonzero.
- gnt_err  out  1  high with gnt_valid when the draw timed out.
- src_req  out  1  draw request to the source.
- src_ack  in  1  source completion; src_data is valid in the same cycle.
- src_data  in  DATA_W  sample from the source.
- period_cfg  in  PERIOD_W  minimum idle cycles between draws.
- busy  out  1  high when state != IDLE or pace counter != 0.

## Operation
- FSM states: IDLE, ISSUE, DELIVER.
- IDLE: if |req and pace==0, select a winner.
  - Winner is the first asserted req at index ptr, ptr+1, … (mod NUM_REQ).
  - Register the winner and go to ISSUE.
- ISSUE: src_req=1.
  - On src_ack=1, capture src_data and go to DELIVER.
  - src_req deasserts in the cycle after the ack.
- DELIVER: for exactly one cycle:
  - gnt_valid[winner]=1, gnt_data=captured sample.
  - ptr ← (winner+1) mod NUM_REQ; pace ← period_cfg.
  - Go to IDLE.
- Pace counter decrements by 1 per cycle while nonzero and saturates at 0. period_cfg is sampled only in DELIVER, so mid-count changes apply to the next draw.
- Once granted, a draw always completes. If the winner drops req during ISSUE, the sample is still delivered and the requester ignores it.
- New req bits arriving during ISSUE or DELIVER wait for the next IDLE arbitration.
- Reset (also mid-transaction):
  - state=IDLE, ptr=0, pace=0.
  - src_req=0, gnt_valid=0, gnt_data=0, gnt_err=0, busy=0.
  - src_req drops in the cycle after rst is sampled; an in-flight sample is discarded and not delivered.
- src_ack outside ISSUE is ignored.

## Timing
- Registered outputs only; no combinational path from req or src_ack to any output.
- req in IDLE with pace==0 at cycle 0:
  - src_req is high at cycle 1.
  - With src_ack at cycle 1, gnt_valid is high at cycle 2.
  - Each extra ack-wait cycle adds one cycle.
- Back-to-back draws with immediate ack are spaced period_cfg+3 cycles, gnt_valid to gnt_valid. Minimum spacing is 3 (period_cfg=0).
- With all req high, each requester is granted once per NUM_REQ draws.

## Configuration
- RAND_DRAW_SCHED_TIMEOUT_EN defined:
  - An ISSUE-cycle counter aborts the draw after TIMEOUT_CYC cycles without src_ack.
  - src_req drops and DELIVER runs normally, with gnt_data=0 and gnt_err=1.
  - ptr and pace update as on a normal draw.
- Undefined: ISSUE waits indefinitely and gnt_err is tied to 0.

## Test plan
- Reset, then single requester: req=4'b0010, src_ack one cycle after src_req, src_data=32'hA5A5_0001, period_cfg=0 → gnt_valid=4'b0010 and gnt_data=32'hA5A5_0001 exactly 2 cycles after req; busy=0 the cycle after.
- Fairness: req=4'b1111 held, immediate ack, period_cfg=0 → grant order 0,1,2,3,0,1…; gnt_valid every 3 cycles.
- Pacing: req=4'b0001 held, period_cfg=10, immediate ack → gnt_valid pulses exactly 13 cycles apart. Change period_cfg to 2 mid-count → current gap stays 13, next gap is 5.
- Slow source: src_ack delayed 7 cycles; a second req arrives during ISSUE → src_req held 8 cycles; the first winner is delivered; the second requester is granted only after the next IDLE arbitration.
- Reset mid-ISSUE: assert rst with src_req=1 → src_req=0 the next cycle, no gnt_valid; after release, req=4'b0100 is granted with ptr restarted at 0.
- With RAND_DRAW_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16, src_ack never asserted → src_req high 16 cycles, then gnt_valid=winner, gnt_data=0, gnt_err=1; the next draw proceeds normally.

Source files
------------

// File: rtl/rand_draw_sched.sv
// Round-robin scheduler sharing one random source among NUM_REQ consumers, with draw pacing.
// Optional ack timeout is enabled by defining RAND_DRAW_SCHED_TIMEOUT_EN.
module rand_draw_sched #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned PERIOD_W    = 16,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  gnt_valid,
    output logic [DATA_W-1:0]   gnt_data,
    output logic                gnt_err,
    output logic                src_req,
    input  logic                src_ack,
    input  logic [DATA_W-1:0]   src_data,
    input  logic [PERIOD_W-1:0] period_cfg,
    output logic                busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYC == 0) begin : g_param_check
        $error("rand_draw_sched: unsupported NUM_REQ or TIMEOUT_CYC");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StDeliver} state_e;

    state_e             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   winner;
    logic [PERIOD_W-1:0] pace;

    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   ptr_next;

    // First asserted request scanning upward from ptr, wrapping at NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            idx = IDX_W'((int'(ptr) + i) % int'(NUM_REQ));
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign ptr_next = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

`ifdef RAND_DRAW_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] tcnt;
`else
    assign gnt_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            ptr       <= '0;
            winner    <= '0;
            pace      <= '0;
            src_req   <= 1'b0;
            gnt_valid <= '0;
            gnt_data  <= '0;
            busy      <= 1'b0;
`ifdef RAND_DRAW_SCHED_TIMEOUT_EN
            gnt_err   <= 1'b0;
            tcnt      <= '0;
`endif
        end else begin
            if (pace != '0) begin
                pace <= pace - 1'b1;
            end
            case (state)
                StIdle: begin
                    if (found && pace == '0) begin
                        winner  <= pick;
                        src_req <= 1'b1;
                        busy    <= 1'b1;
                        state   <= StIssue;
`ifdef RAND_DRAW_SCHED_TIMEOUT_EN
                        tcnt    <= '0;
`endif
                    end else begin
                        // Still busy next cycle only if the decremented pace stays nonzero.
                        busy <= (pace > PERIOD_W'(1));
                    end
                end
                StIssue: begin
                    busy <= 1'b1;
                    if (src_ack) begin
                        src_req   <= 1'b0;
                        gnt_valid <= ONE_HOT0 << winner;
                        gnt_data  <= src_data;
                        state     <= StDeliver;
                    end
`ifdef RAND_DRAW_SCHED_TIMEOUT_EN
                    else if (tcnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        src_req   <= 1'b0;
                        gnt_valid <= ONE_HOT0 << winner;
                        gnt_data  <= '0;
                        gnt_err   <= 1'b1;
                        state     <= StDeliver;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                StDeliver: begin
                    gnt_valid <= '0;
                    gnt_data  <= '0;
                    ptr       <= ptr_next;
                    pace      <= period_cfg;
                    busy      <= (period_cfg != '0);
                    state     <= StIdle;
`ifdef RAND_DRAW_SCHED_TIMEOUT_EN
                    gnt_err   <= 1'b0;
`endif
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rand_draw_sched.sv
// Directed bench for rand_draw_sched: reset, single draw, fairness, pacing, slow source,
// reset mid-draw, and (with RAND_DRAW_SCHED_TIMEOUT_EN) the ack timeout.
module tb_rand_draw_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  gnt_valid;
    logic [31:0] gnt_data;
    logic        gnt_err;
    logic        src_req;
    logic        src_ack = 1'b0;
    logic [31:0] src_data = 32'hA5A5_0001;
    logic [15:0] period_cfg = '0;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_gnt = 0;
    int srq_cnt = 0;
    int          g_cyc [64];
    logic [3:0]  g_vld [64];
    logic [31:0] g_dat [64];
    logic        g_err [64];
    bit auto_drop = 1'b1;
    bit ack_en = 1'b1;
    int ack_delay = 0;
    int src_cnt = 0;

    rand_draw_sched #(
        .NUM_REQ(4),
        .DATA_W(32),
        .PERIOD_W(16),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt_valid(gnt_valid),
        .gnt_data(gnt_data),
        .gnt_err(gnt_err),
        .src_req(src_req),
        .src_ack(src_ack),
        .src_data(src_data),
        .period_cfg(period_cfg),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Source model: ack once src_req has been high for ack_delay cycles; new sample per ack.
    always @(posedge clk) begin
        #1;
        if (src_ack) src_data = src_data + 32'd1;
        if (src_req) begin
            src_ack = ack_en && (src_cnt == ack_delay);
            src_cnt++;
        end else begin
            src_ack = 1'b0;
            src_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: log grants and src_req at the negedge, then advance to just after the posedge.
    task automatic tick();
        logic [3:0] g;
        @(negedge clk);
        if (gnt_valid != '0 && n_gnt < 64) begin
            g_cyc[n_gnt] = cyc;
            g_vld[n_gnt] = gnt_valid;
            g_dat[n_gnt] = gnt_data;
            g_err[n_gnt] = gnt_err;
            n_gnt++;
        end
        if (src_req) srq_cnt++;
        g = gnt_valid;
        @(posedge clk);
        #1;
        cyc++;
        if (auto_drop) req = req & ~g;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        ticks(2);
        rst = 1'b0;
    endtask

    initial begin
        int t0, t1, b, s;

        // Reset state
        do_reset();
        check("rst_src_req", src_req, 1'b0);
        check("rst_gnt_valid", gnt_valid, 4'b0000);
        check("rst_gnt_data", gnt_data, 32'h0);
        check("rst_gnt_err", gnt_err, 1'b0);
        check("rst_busy", busy, 1'b0);

        // Single requester, ack in the first ISSUE cycle
        auto_drop = 1'b1;
        period_cfg = 16'd0;
        req = 4'b0010;
        tick();
        check("t1_src_req", src_req, 1'b1);
        check("t1_busy_issue", busy, 1'b1);
        tick();
        check("t1_gnt_valid", gnt_valid, 4'b0010);
        check("t1_gnt_data", gnt_data, 32'hA5A5_0001);
        check("t1_gnt_err", gnt_err, 1'b0);
        check("t1_src_req_drop", src_req, 1'b0);
        tick();
        check("t1_busy_after", busy, 1'b0);
        check("t1_gnt_pulse", gnt_valid, 4'b0000);

        // Fairness with all requests held
        do_reset();
        auto_drop = 1'b0;
        b = n_gnt;
        t0 = cyc;
        req = 4'b1111;
        ticks(20);
        req = '0;
        ticks(6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("fair_vld%0d", k), g_vld[b+k], 4'b0001 << (k % 4));
            check($sformatf("fair_cyc%0d", k), g_cyc[b+k] - t0, 2 + 3 * k);
        end
        check("fair_data0", g_dat[b], 32'hA5A5_0002);
        check("fair_data1", g_dat[b+1], 32'hA5A5_0003);

        // Pacing, with period_cfg changed mid-count
        do_reset();
        auto_drop = 1'b0;
        period_cfg = 16'd10;
        b = n_gnt;
        t0 = cyc;
        req = 4'b0001;
        ticks(6);
        check("pace_busy", busy, 1'b1);
        period_cfg = 16'd2;
        ticks(20);
        req = '0;
        period_cfg = 16'd0;
        ticks(15);
        check("pace_first", g_cyc[b] - t0, 2);
        check("pace_gap13", g_cyc[b+1] - g_cyc[b], 13);
        check("pace_gap5", g_cyc[b+2] - g_cyc[b+1], 5);
        check("pace_idle_busy", busy, 1'b0);

        // Slow source; second request arrives during ISSUE
        do_reset();
        auto_drop = 1'b1;
        ack_delay = 7;
        b = n_gnt;
        t0 = cyc;
        s = srq_cnt;
        req = 4'b0001;
        ticks(3);
        req = req | 4'b0100;
        ticks(6);
        check("slow_srq_len", srq_cnt - s, 8);
        ticks(14);
        check("slow_n_gnt", n_gnt - b, 2);
        check("slow_vld0", g_vld[b], 4'b0001);
        check("slow_cyc0", g_cyc[b] - t0, 9);
        check("slow_vld1", g_vld[b+1], 4'b0100);
        check("slow_cyc1", g_cyc[b+1] - t0, 19);

        // Reset mid-ISSUE; ptr was 3 before the reset
        b = n_gnt;
        req = 4'b0001;
        ticks(3);
        check("rmid_src_req_pre", src_req, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmid_src_req", src_req, 1'b0);
        check("rmid_busy", busy, 1'b0);
        req = '0;
        ticks(2);
        ack_delay = 0;
        t1 = cyc;
        req = 4'b1100;
        ticks(8);
        check("rmid_n_gnt", n_gnt - b, 2);
        check("rmid_vld0", g_vld[b], 4'b0100);
        check("rmid_cyc0", g_cyc[b] - t1, 2);
        check("rmid_vld1", g_vld[b+1], 4'b1000);

`ifdef RAND_DRAW_SCHED_TIMEOUT_EN
        // Source never acks: abort after 16 ISSUE cycles
        do_reset();
        auto_drop = 1'b1;
        ack_en = 1'b0;
        b = n_gnt;
        s = srq_cnt;
        t0 = cyc;
        req = 4'b0010;
        ticks(20);
        check("to_srq_len", srq_cnt - s, 16);
        check("to_cyc", g_cyc[b] - t0, 17);
        check("to_vld", g_vld[b], 4'b0010);
        check("to_data", g_dat[b], 32'h0);
        check("to_err", g_err[b], 1'b1);
        ack_en = 1'b1;
        t1 = cyc;
        req = 4'b0001;
        ticks(5);
        check("to_next_vld", g_vld[b+1], 4'b0001);
        check("to_next_cyc", g_cyc[b+1] - t1, 2);
        check("to_next_err", g_err[b+1], 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
